// File: rtl/conv_pkg.sv
// Shared convolution definitions: default kernel/data sizes, control state encoding
// and the packed-window element offset used by the window generator and MAC unit.
package conv_pkg;

  localparam int unsigned DefDataWidth = 9;
  localparam int unsigned DefKH        = 3;
  localparam int unsigned DefKW        = 3;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } conv_state_e;

  // Bit offset of window element [r][c]; [0][0] is the top-left (oldest) pixel.
  function automatic int unsigned win_off(input int unsigned r, input int unsigned c,
                                          input int unsigned kw, input int unsigned dw);
    return (r * kw + c) * dw;
  endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out streams of the window generator. master = upstream/downstream side,
// slave = the generator itself.
interface conv_window_gen_if #(
  parameter int unsigned IMG_W      = 28,
  parameter int unsigned IMG_H      = 28,
  parameter int unsigned K_H        = conv_pkg::DefKH,
  parameter int unsigned K_W        = conv_pkg::DefKW,
  parameter int unsigned DATA_WIDTH = conv_pkg::DefDataWidth
) ();

  logic                              in_valid;
  logic                              in_ready;
  logic signed [DATA_WIDTH-1:0]      in_pixel;
  logic                              win_valid;
  logic                              win_ready;
  logic [K_H*K_W*DATA_WIDTH-1:0]     conv_win;
  logic [$clog2(IMG_H)-1:0]          win_row;
  logic [$clog2(IMG_W)-1:0]          win_col;

  modport master (
    output in_valid, in_pixel, win_ready,
    input  in_ready, win_valid, conv_win, win_row, win_col
  );

  modport slave (
    input  in_valid, in_pixel, win_ready,
    output in_ready, win_valid, conv_win, win_row, win_col
  );

endinterface

// File: rtl/conv_line_buffer.sv
// Single-port row store, one feature-map row deep. The read port shows the old contents
// of the addressed column, so a write in the same cycle is read-before-write.
module conv_line_buffer #(
  parameter int unsigned DEPTH = 28,
  parameter int unsigned WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming K_H x K_W window generator (stride 1, no padding) feeding the MAC unit,
// with a single-entry registered window output.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W      = 28,
  parameter int unsigned IMG_H      = 28,
  parameter int unsigned K_H        = DefKH,
  parameter int unsigned K_W        = DefKW,
  parameter int unsigned DATA_WIDTH = DefDataWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             frame_done,
  conv_window_gen_if.slave bus
);

  localparam int unsigned RowW  = $clog2(IMG_H);
  localparam int unsigned ColW  = $clog2(IMG_W);
  localparam int unsigned NumLb = K_H - 1;
  localparam int unsigned WinW  = K_H * K_W * DATA_WIDTH;

  localparam logic [RowW-1:0] LastRow  = RowW'(IMG_H - 1);
  localparam logic [ColW-1:0] LastCol  = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] FirstRow = RowW'(K_H - 1);
  localparam logic [ColW-1:0] FirstCol = ColW'(K_W - 1);

  conv_state_e           state_q, state_d;
  logic [RowW-1:0]       row_q, row_d;
  logic [ColW-1:0]       col_q, col_d;
  logic                  win_valid_q, win_valid_d;
  logic [WinW-1:0]       conv_win_q, conv_win_d;
  logic [RowW-1:0]       win_row_q, win_row_d;
  logic [ColW-1:0]       win_col_q, win_col_d;
  logic                  frame_done_q, frame_done_d;

  logic [DATA_WIDTH-1:0] sr_q [K_H][K_W];
  logic [DATA_WIDTH-1:0] sr_d [K_H][K_W];
  logic [DATA_WIDTH-1:0] lb_rdata [NumLb];
  logic [DATA_WIDTH-1:0] lb_wdata [NumLb];

  logic accept, emit, last_col;

  assign bus.in_ready  = (state_q == StRun) && (!win_valid_q || bus.win_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign last_col      = (col_q == LastCol);
  assign emit          = accept && (row_q >= FirstRow) && (col_q >= FirstCol);
  assign bus.win_valid = win_valid_q;
  assign bus.conv_win  = conv_win_q;
  assign bus.win_row   = win_row_q;
  assign bus.win_col   = win_col_q;
  assign busy          = (state_q != StIdle);
  assign frame_done    = frame_done_q;

  // Cascaded rows: buffer i holds row r-K_H+1+i, the newest buffer takes the incoming pixel.
  for (genvar i = 0; i < NumLb; i++) begin : g_lb
    if (i == NumLb - 1) begin : g_newest
      assign lb_wdata[i] = bus.in_pixel;
    end else begin : g_older
      assign lb_wdata[i] = lb_rdata[i+1];
    end

    conv_line_buffer #(
      .DEPTH(IMG_W),
      .WIDTH(DATA_WIDTH)
    ) u_line_buffer (
      .clk  (clk),
      .we   (accept),
      .addr (col_q),
      .wdata(lb_wdata[i]),
      .rdata(lb_rdata[i])
    );
  end

  always_comb begin
    sr_d = sr_q;
    if (accept) begin
      for (int unsigned r = 0; r < K_H; r++) begin
        for (int unsigned c = 0; c < K_W - 1; c++) begin
          sr_d[r][c] = sr_q[r][c+1];
        end
      end
      for (int unsigned r = 0; r < NumLb; r++) begin
        sr_d[r][K_W-1] = lb_rdata[r];
      end
      sr_d[K_H-1][K_W-1] = bus.in_pixel;
    end
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          row_d   = '0;
          col_d   = '0;
        end
      end
      StRun: begin
        if (accept) begin
          if (last_col) begin
            col_d = '0;
            if (row_q == LastRow) begin
              state_d = StDrain;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (win_valid_q && bus.win_ready) begin
          state_d      = StIdle;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Emission only happens on an accept, and accept implies the output slot is free.
  always_comb begin
    win_valid_d = win_valid_q;
    conv_win_d  = conv_win_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    if (emit) begin
      win_valid_d = 1'b1;
      win_row_d   = row_q - FirstRow;
      win_col_d   = col_q - FirstCol;
      for (int unsigned r = 0; r < K_H; r++) begin
        for (int unsigned c = 0; c < K_W; c++) begin
          conv_win_d[win_off(r, c, K_W, DATA_WIDTH) +: DATA_WIDTH] = sr_d[r][c];
        end
      end
    end else if (win_valid_q && bus.win_ready) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      row_q        <= '0;
      col_q        <= '0;
      win_valid_q  <= 1'b0;
      conv_win_q   <= '0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      win_valid_q  <= win_valid_d;
      conv_win_q   <= conv_win_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 5x4 frame: a scoreboard of expected windows built
// from the driven image, popped on every output handshake.
module tb_conv_window_gen;

  localparam int unsigned W    = 5;
  localparam int unsigned H    = 4;
  localparam int unsigned KH   = 3;
  localparam int unsigned KW   = 3;
  localparam int unsigned DW   = 9;
  localparam int unsigned NPIX = W * H;
  localparam int unsigned NWIN = (H - KH + 1) * (W - KW + 1);
  localparam int unsigned WINW = KH * KW * DW;
  localparam int unsigned RW   = $clog2(H);
  localparam int unsigned CW   = $clog2(W);

  logic clk = 1'b0;
  logic rst, start, busy, frame_done;

  conv_window_gen_if #(.IMG_W(W), .IMG_H(H), .K_H(KH), .K_W(KW), .DATA_WIDTH(DW)) bus ();

  conv_window_gen #(
    .IMG_W(W), .IMG_H(H), .K_H(KH), .K_W(KW), .DATA_WIDTH(DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .frame_done(frame_done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WINW-1:0] win;
    logic [RW-1:0]   row;
    logic [CW-1:0]   col;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pix[NPIX];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WINW-1:0] model_win(input int r, input int c);
    logic [WINW-1:0] w;
    w = '0;
    for (int i = 0; i < KH; i++) begin
      for (int j = 0; j < KW; j++) begin
        w[(i*KW+j)*DW +: DW] = DW'(pix[(r-KH+1+i)*W + (c-KW+1+j)]);
      end
    end
    return w;
  endfunction

  function automatic int el(input logic [WINW-1:0] w, input int r, input int c);
    logic signed [DW-1:0] v;
    v = w[(r*KW+c)*DW +: DW];
    return int'(v);
  endfunction

  task automatic fill(input int base);
    for (int i = 0; i < NPIX; i++) pix[i] = base + i;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " in_ready"}, bus.in_ready, 0);
    check({tag, " win_valid"}, bus.win_valid, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " frame_done"}, frame_done, 0);
    check({tag, " conv_win"}, bus.conv_win, 0);
    check({tag, " win_row"}, bus.win_row, 0);
    check({tag, " win_col"}, bus.win_col, 0);
  endtask

  task automatic run_frame(input string name, input int stall_cycles, input bit rand_valid,
                           input int start_at, output int nwin, output int ndone,
                           output logic [WINW-1:0] first_win, output logic [WINW-1:0] last_win);
    int   idx, stall_left, cyc;
    bit   exp_wv, stalled_once, done;
    exp_t e;
    idx = 0; stall_left = 0; cyc = 0; exp_wv = 0; stalled_once = 0; done = 0;
    nwin = 0; ndone = 0; first_win = '0; last_win = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (cyc < 400 && !done) begin
      bus.in_valid = (idx < NPIX) && (!rand_valid || $urandom_range(0, 1) == 1);
      if (idx < NPIX) bus.in_pixel = DW'(pix[idx]);
      if (stall_cycles > 0 && !stalled_once && bus.win_valid) begin
        stalled_once = 1;
        stall_left   = stall_cycles;
      end
      bus.win_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      start = (cyc == start_at);
      #1;
      if (cyc == 0) check({name, " busy"}, busy, 1);
      if (exp_wv) check({name, " latency"}, bus.win_valid, 1);
      exp_wv = 0;
      if (frame_done) ndone++;
      if (bus.win_valid && !bus.win_ready) begin
        if (sb.size() > 0) check({name, " stall conv_win"}, bus.conv_win, sb[0].win);
        else check({name, " stall sb"}, 0, 1);
        check({name, " stall in_ready"}, bus.in_ready, 0);
      end
      if (bus.win_valid && bus.win_ready) begin
        if (sb.size() == 0) begin
          check({name, " extra window"}, 1, 0);
        end else begin
          e = sb.pop_front();
          check({name, " conv_win"}, bus.conv_win, e.win);
          check({name, " win_row"}, bus.win_row, e.row);
          check({name, " win_col"}, bus.win_col, e.col);
          if (nwin == 0) first_win = bus.conv_win;
          last_win = bus.conv_win;
          nwin++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        if (idx / W >= KH - 1 && idx % W >= KW - 1) begin
          e.win = model_win(idx / W, idx % W);
          e.row = RW'(idx / W - (KH - 1));
          e.col = CW'(idx % W - (KW - 1));
          sb.push_back(e);
          exp_wv = 1;
        end
        idx++;
      end
      done = (idx == NPIX) && (sb.size() == 0) && (ndone > 0);
      @(negedge clk);
      cyc++;
    end
    check({name, " completes in budget"}, done, 1);
    bus.in_valid  = 1'b0;
    bus.win_ready = 1'b1;
    start         = 1'b0;
    repeat (4) begin
      #1;
      if (frame_done) ndone++;
      @(negedge clk);
    end
    check({name, " busy after frame"}, busy, 0);
    sb.delete();
  endtask

  int              nwin, ndone;
  logic [WINW-1:0] fw, lw;

  initial begin
    rst = 1'b1; start = 1'b0;
    bus.in_valid = 1'b0; bus.in_pixel = '0; bus.win_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("por");
    rst = 1'b0;
    @(negedge clk);
    check_reset("idle");

    // Free-running frame with known corner values.
    fill(0);
    run_frame("free", 0, 0, -1, nwin, ndone, fw, lw);
    check("free count", nwin, NWIN);
    check("free frame_done", ndone, 1);
    check("free first [0][0]", el(fw, 0, 0), 0);
    check("free first [0][2]", el(fw, 0, 2), 2);
    check("free first [1][1]", el(fw, 1, 1), 6);
    check("free first [2][2]", el(fw, 2, 2), 12);
    check("free last [0][0]", el(lw, 0, 0), 7);
    check("free last [2][2]", el(lw, 2, 2), 19);

    run_frame("stall", 5, 0, -1, nwin, ndone, fw, lw);
    check("stall count", nwin, NWIN);
    check("stall frame_done", ndone, 1);

    run_frame("rand", 0, 1, -1, nwin, ndone, fw, lw);
    check("rand count", nwin, NWIN);
    check("rand frame_done", ndone, 1);

    fill(0);
    pix[0] = -256; pix[1] = 255; pix[2] = -1;
    run_frame("signed", 0, 0, -1, nwin, ndone, fw, lw);
    check("signed [0][0]", el(fw, 0, 0), -256);
    check("signed [0][1]", el(fw, 0, 1), 255);
    check("signed [0][2]", el(fw, 0, 2), -1);

    // Reset after nine pixels, then a clean frame.
    fill(0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.in_pixel = DW'(pix[i]);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset("mid rst");
    @(negedge clk);
    rst = 1'b0;
    fill(100);
    run_frame("after rst", 0, 0, -1, nwin, ndone, fw, lw);
    check("after rst count", nwin, NWIN);
    check("after rst min first", el(fw, 0, 0), 100);

    fill(0);
    run_frame("start in run", 0, 0, 8, nwin, ndone, fw, lw);
    check("start in run count", nwin, NWIN);
    check("start in run frame_done", ndone, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
Streaming 3x3 window generator that sits directly upstream of the convolution MAC unit. It accepts one signed feature-map pixel per handshake in raster order, buffers K_H-1 full rows, and emits every valid K_H x K_W window (stride 1, no padding) through a registered valid/ready output. The window bus feeds the MAC unit's conv_win input as-is.

Parameters:
IMG_W, 28, feature-map width in pixels (>= K_W)
IMG_H, 28, feature-map height in pixels (>= K_H)
K_H, 3, window rows
K_W, 3, window columns
DATA_WIDTH, 9, signed pixel width

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a frame; honoured only in IDLE
in_valid  in  1  upstream pixel valid
in_ready  out  1  pixel accepted when in_valid && in_ready
in_pixel  in  DATA_WIDTH  signed pixel, raster order
win_valid  out  1  window register holds a valid window
win_ready  in  1  downstream consumes the window when win_valid && win_ready
conv_win  out  K_H*K_W*DATA_WIDTH  packed window; element [r][c] at bits (r*K_W+c)*DATA_WIDTH +: DATA_WIDTH; [0][0] is top-left (oldest)
win_row  out  $clog2(IMG_H)  output row index of the current window (top-left pixel row)
win_col  out  $clog2(IMG_W)  output column index of the current window
busy  out  1  high in RUN and DRAIN
frame_done  out  1  one-cycle pulse after the final window is consumed

Behaviour:
- Reset: state=IDLE; in_ready, win_valid, busy and frame_done = 0; conv_win, win_row and win_col = 0; pixel row/col counters = 0. Line-buffer RAM is not cleared. Its contents are don't-care because every row is rewritten before use.
- States:
  - IDLE: in_ready=0. start -> RUN and clears the counters.
  - RUN: in_ready = !win_valid || win_ready, so the output register acts as a single-entry skid. When the last pixel (IMG_H-1, IMG_W-1) is accepted -> DRAIN.
  - DRAIN: in_ready=0. When the final window handshakes -> IDLE and frame_done=1 for one cycle.
- start outside IDLE is ignored.
- Pixel accept at (r,c):
  - Shift in_pixel into window column K_W-1.
  - The window's column j for rows 0..K_H-2 comes from line buffers (row r-K_H+1+j..r-1 at column c).
  - Write in_pixel into the line buffer at column c. Buffers rotate at end of row.
  - Column counter wraps at IMG_W-1 and row increments. The row counter stops at IMG_H-1.
- Window emit: if r >= K_H-1 and c >= K_W-1, then on the next edge:
  - conv_win = pixels rows r-K_H+1..r, cols c-K_W+1..c;
  - win_row = r-K_H+1, win_col = c-K_W+1;
  - win_valid = 1.
  - Latency from accepting the window's last pixel: 1 cycle.
- Window-register update on an edge:
  - If a handshake occurs with no new window, win_valid drops.
  - If a handshake and a new window coincide, the register reloads and win_valid stays 1.
  - If win_valid && !win_ready, the register, win_row and win_col hold stable, and in_ready=0.
- Row start: shift-register columns keep the previous row's tail. This is harmless because emission requires c >= K_W-1.
- Widths: pixels are passed through unmodified (sign preserved). No arithmetic on data.
- Windows per frame: (IMG_H-K_H+1)*(IMG_W-K_W+1).
- Reset mid-frame: immediate return to reset values. A following start begins a clean frame.

Decomposition:
- Shared package conv_pkg holds:
  - DATA_WIDTH, K_H, K_W defaults (shared with the MAC unit);
  - the state enum {IDLE, RUN, DRAIN};
  - a function for the window bit offset (r*K_W+c)*DATA_WIDTH.
- One sub-module, conv_line_buffer: single-port, depth-IMG_W, DATA_WIDTH-wide read-before-write row store, instantiated K_H-1 times.

Test Plan:
- IMG_W=5, IMG_H=4, pixel = r*5+c, win_ready=1, in_valid=1 -> first win_valid the cycle after pixel 12 is accepted, with [0][0]=0, [0][2]=2, [1][1]=6, [2][2]=12, win_row=0, win_col=0. Exactly 6 windows, last one [0][0]=7, [2][2]=19, then frame_done pulses once.
- Same frame with win_ready low for 5 cycles at the first window -> conv_win, win_row and win_col are stable, in_ready=0 throughout, no pixel lost. The window sequence matches the free-running case.
- in_valid toggled randomly (50%) with win_ready=1 -> identical window sequence, win_col wraps 2->0 and win_row increments.
- Pixel values -256, 255, -1 in the first window -> bits read back as -256, 255, -1 (sign preserved).
- Assert rst for 1 cycle after 9 pixels, then start with a new frame of pixel = 100+idx -> no window contains values <100. Output count is 6.
- start pulsed during RUN -> ignored; counters unaffected; exactly one frame_done.
